noc_local_port: RTL and testbench
=================================

Name: noc_local_port

Overview:
- Switch-side endpoint of the PE link: the switch's local port, facing the PE interface block.
- Ingress: accepts flits from the PE, buffers them in a 2-entry skid FIFO, computes the XY-routing output direction from the header, and presents them to the router crossbar.
- Egress: accepts locally-destined flits from the crossbar, buffers them in a 2-entry FIFO, and delivers them to the PE.

Parameters:
- X, 0: this node's column coordinate
- Y, 0: this node's row coordinate
- total_width, 280: flit width in bits
- x_size, 4: mesh columns; XW = max(1, clog2(x_size))
- y_size, 4: mesh rows; YW = max(1, clog2(y_size))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pe_data  in  total_width  flit from PE
- pe_valid  in  1  PE flit valid
- pe_ready  out  1  port can accept PE flit
- xbar_out_data  out  total_width  flit to crossbar
- xbar_out_valid  out  1  crossbar flit valid
- xbar_out_ready  in  1  crossbar accepts
- xbar_out_port  out  5  one-hot direction {W,E,S,N,L} = bits [4:0]
- xbar_in_data  in  total_width  locally-destined flit from crossbar
- xbar_in_valid  in  1  crossbar flit valid
- xbar_in_ready  out  1  egress can accept
- to_pe_data  out  total_width  flit to PE
- to_pe_valid  out  1  flit to PE valid
- to_pe_ready  in  1  PE accepts (PE normally ties to 1)

Behaviour:
- Clock and reset:
  - Single clock.
  - rst sampled only on the clk rising edge.
  - Reset clears both FIFOs (pointers, counts) and drives all outputs as follows: valids 0, readies 0 during reset then 1 the cycle after, data 0, port 0.
  - Reset mid-transfer discards buffered flits; no partial flit survives.
- Transfer rule: a transfer occurs on a cycle where valid && ready. Data, port and valid stay stable while valid && !ready.
- Ingress FIFO:
  - 2 entries; each stores the flit plus its 5-bit port computed at write time.
  - pe_ready = (count < 2); registered, not combinationally dependent on xbar_out_ready.
  - xbar_out_valid = (count > 0); head presented directly from storage.
  - Latency: PE accept in cycle N gives xbar_out_valid in cycle N+1.
  - Simultaneous push and pop with count == 2 is not allowed, because pe_ready is 0. With count == 1, simultaneous push and pop leaves count at 1 and throughput is 1 flit/cycle.
  - Pointers are 1 bit wide and wrap 1→0.
- Header decode:
  - dst_x = flit[XW-1:0]; dst_y = flit[XW+YW-1:XW].
  - Comparisons are unsigned.
- XY route:
  - dst_x > X → E
  - dst_x < X → W
  - otherwise dst_y > Y → N
  - dst_y < Y → S
  - otherwise L (self-addressed; the crossbar loops it back).
  - Out-of-range coordinates (dst_x ≥ x_size) route E or N by comparison; no trap.
- Egress FIFO:
  - Identical 2-entry structure.
  - xbar_in_ready = (count < 2); to_pe_valid = (count > 0).
  - Latency: 1 cycle.
- Flit ordering: flits leave each direction in arrival order; no reordering and no drop.
- Independence: ingress and egress paths are independent; simultaneous traffic on both paths never stalls either one.

Optional Feature:
- Macro: NOC_LOCAL_PORT_STATS_EN.
- Defined:
  - Adds outputs stat_in_cnt[31:0] and stat_out_cnt[31:0].
  - stat_in_cnt increments on each PE→port transfer; stat_out_cnt increments on each port→PE transfer.
  - Counters wrap at 2^32 and are cleared by rst.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Shared package noc_pkg:
  - Direction index localparams DIR_L=0, DIR_N=1, DIR_S=2, DIR_E=3, DIR_W=4.
  - Port vector width 5.
  - Header field offsets.
- Sub-module noc_skid_fifo (parameter WIDTH; depth 2), instantiated twice: ingress with WIDTH = total_width+5, egress with WIDTH = total_width.

Test Plan:
- Reset: assert rst 3 cycles with pe_valid=1 → all valids 0, port 0; pe_ready=1 and xbar_in_ready=1 one cycle after rst falls.
- Routing, X=1, Y=1, 4x4 mesh; send single flits with dst (3,1), (0,1), (1,3), (1,0), (1,1) → xbar_out_port = 5'b01000, 5'b10000, 5'b00010, 5'b00100, 5'b00001 respectively, each valid 1 cycle after accept.
- Backpressure: hold xbar_out_ready=0 and push 3 flits A, B, C → A and B accepted; pe_ready=0 after 2nd accept; C held. Release ready → output order A, B, C; no loss.
- Streaming: xbar_out_ready=1 and a 10-flit burst on consecutive cycles → 10 outputs on 10 consecutive cycles, in order.
- Egress: to_pe_ready toggling 1,0,1,0 with 4 crossbar flits → all 4 delivered in order; xbar_in_ready drops only when 2 entries are held.
- Mid-operation reset: ingress holding 2 flits, assert rst 1 cycle → xbar_out_valid=0 next cycle, no stale flit afterwards. With NOC_LOCAL_PORT_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC local port: direction indices, port vector width,
// header field offsets and the XY routing decision.
package noc_pkg;

    localparam int PORT_W = 5;

    localparam int DIR_L = 0;
    localparam int DIR_N = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_W = 4;

    // Destination X sits at the flit LSBs; destination Y follows immediately above it.
    localparam int HDR_X_LSB = 0;

    function automatic logic [PORT_W-1:0] xy_route(
        input int unsigned dst_x,
        input int unsigned dst_y,
        input int unsigned my_x,
        input int unsigned my_y
    );
        logic [PORT_W-1:0] w_port;
        w_port = '0;
        if (dst_x > my_x) begin
            w_port[DIR_E] = 1'b1;
        end else if (dst_x < my_x) begin
            w_port[DIR_W] = 1'b1;
        end else if (dst_y > my_y) begin
            w_port[DIR_N] = 1'b1;
        end else if (dst_y < my_y) begin
            w_port[DIR_S] = 1'b1;
        end else begin
            w_port[DIR_L] = 1'b1;
        end
        return w_port;
    endfunction

endpackage

// File: rtl/noc_skid_fifo.sv
// Two-entry FIFO with a registered input ready; the head entry is presented
// straight from storage so the output path has no combinational depth.
module noc_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push       = i_valid & r_ready;
    assign w_pop        = (r_count != 2'd0) & i_ready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Ready looks at the post-update occupancy so it never depends on i_ready this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'd2);
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/noc_local_port.sv
// Switch-side local port: PE ingress with XY route tagging, crossbar egress to the PE.
// Optional transfer counters are built when NOC_LOCAL_PORT_STATS_EN is defined.
module noc_local_port
    import noc_pkg::*;
#(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int total_width = 280,
    parameter int x_size      = 4,
    parameter int y_size      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] pe_data,
    input  logic                   pe_valid,
    output logic                   pe_ready,
    output logic [total_width-1:0] xbar_out_data,
    output logic                   xbar_out_valid,
    input  logic                   xbar_out_ready,
    output logic [PORT_W-1:0]      xbar_out_port,
    input  logic [total_width-1:0] xbar_in_data,
    input  logic                   xbar_in_valid,
    output logic                   xbar_in_ready,
    output logic [total_width-1:0] to_pe_data,
    output logic                   to_pe_valid,
    input  logic                   to_pe_ready
`ifdef NOC_LOCAL_PORT_STATS_EN
    ,
    output logic [31:0]            stat_in_cnt,
    output logic [31:0]            stat_out_cnt
`endif
);

    localparam int XW = (x_size > 1) ? $clog2(x_size) : 1;
    localparam int YW = (y_size > 1) ? $clog2(y_size) : 1;
    localparam int HDR_Y_LSB = HDR_X_LSB + XW;
    localparam int IN_W = total_width + PORT_W;

    logic [XW-1:0]          w_dst_x;
    logic [YW-1:0]          w_dst_y;
    logic [PORT_W-1:0]      w_route;
    logic [IN_W-1:0]        w_in_head;

    assign w_dst_x = pe_data[HDR_X_LSB +: XW];
    assign w_dst_y = pe_data[HDR_Y_LSB +: YW];
    assign w_route = xy_route(32'(w_dst_x), 32'(w_dst_y), 32'(X), 32'(Y));

    // The route is fixed at write time and travels with the flit.
    noc_skid_fifo #(.WIDTH(IN_W)) u_ingress (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({w_route, pe_data}),
        .i_valid (pe_valid),
        .o_ready (pe_ready),
        .o_data  (w_in_head),
        .o_valid (xbar_out_valid),
        .i_ready (xbar_out_ready)
    );

    assign xbar_out_data = w_in_head[total_width-1:0];
    assign xbar_out_port = w_in_head[IN_W-1:total_width];

    noc_skid_fifo #(.WIDTH(total_width)) u_egress (
        .clk     (clk),
        .rst     (rst),
        .i_data  (xbar_in_data),
        .i_valid (xbar_in_valid),
        .o_ready (xbar_in_ready),
        .o_data  (to_pe_data),
        .o_valid (to_pe_valid),
        .i_ready (to_pe_ready)
    );

`ifdef NOC_LOCAL_PORT_STATS_EN
    logic [31:0] r_stat_in_cnt;
    logic [31:0] r_stat_out_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_in_cnt  <= '0;
            r_stat_out_cnt <= '0;
        end else begin
            if (pe_valid && pe_ready) begin
                r_stat_in_cnt <= r_stat_in_cnt + 32'd1;
            end
            if (to_pe_valid && to_pe_ready) begin
                r_stat_out_cnt <= r_stat_out_cnt + 32'd1;
            end
        end
    end

    assign stat_in_cnt  = r_stat_in_cnt;
    assign stat_out_cnt = r_stat_out_cnt;
`endif

endmodule

// File: tb/tb_noc_local_port.sv
// Bench for noc_local_port at node (1,1) of a 4x4 mesh with 16-bit flits; directed
// steps followed by random traffic, checked against queue-based flow models.
module tb_noc_local_port;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] pe_data;
    logic          pe_valid;
    logic          pe_ready;
    logic [TW-1:0] xbar_out_data;
    logic          xbar_out_valid;
    logic          xbar_out_ready;
    logic [4:0]    xbar_out_port;
    logic [TW-1:0] xbar_in_data;
    logic          xbar_in_valid;
    logic          xbar_in_ready;
    logic [TW-1:0] to_pe_data;
    logic          to_pe_valid;
    logic          to_pe_ready;
`ifdef NOC_LOCAL_PORT_STATS_EN
    logic [31:0]   stat_in_cnt;
    logic [31:0]   stat_out_cnt;
`endif

    noc_local_port #(
        .X(1), .Y(1), .total_width(TW), .x_size(4), .y_size(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_data        (pe_data),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .xbar_out_data  (xbar_out_data),
        .xbar_out_valid (xbar_out_valid),
        .xbar_out_ready (xbar_out_ready),
        .xbar_out_port  (xbar_out_port),
        .xbar_in_data   (xbar_in_data),
        .xbar_in_valid  (xbar_in_valid),
        .xbar_in_ready  (xbar_in_ready),
        .to_pe_data     (to_pe_data),
        .to_pe_valid    (to_pe_valid),
        .to_pe_ready    (to_pe_ready)
`ifdef NOC_LOCAL_PORT_STATS_EN
        ,
        .stat_in_cnt    (stat_in_cnt),
        .stat_out_cnt   (stat_out_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: flits owed on each side, in order, plus transfer tallies.
    logic [TW+4:0] iq[$];
    logic [TW-1:0] eq[$];
    int            in_cnt = 0;
    int            out_cnt = 0;
    int            xbar_pops = 0;
    int            pe_pops = 0;
    logic          prev_rst = 1'b1;
    logic          started = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // XY routing: X first, then Y, self-addressed goes local. Vector is {W,E,S,N,L}.
    function automatic logic [4:0] ref_route(input logic [TW-1:0] f);
        int dx;
        int dy;
        dx = int'(f[1:0]);
        dy = int'(f[3:2]);
        if (dx > 1)      return 5'b01000;
        else if (dx < 1) return 5'b10000;
        else if (dy > 1) return 5'b00010;
        else if (dy < 1) return 5'b00100;
        else             return 5'b00001;
    endfunction

    function automatic logic [TW-1:0] mk_flit(input int dx, input int dy);
        logic [TW-1:0] f;
        f = TW'($urandom);
        f[1:0] = 2'(dx);
        f[3:2] = 2'(dy);
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            iq.delete();
            eq.delete();
            in_cnt = 0;
            out_cnt = 0;
            prev_rst = 1'b1;
            started = 1'b1;
        end else if (started) begin
            check("pe_ready_occupancy", pe_ready, !prev_rst && iq.size() < 2);
            check("xbar_out_valid_occupancy", xbar_out_valid, iq.size() > 0);
            check("xbar_in_ready_occupancy", xbar_in_ready, !prev_rst && eq.size() < 2);
            check("to_pe_valid_occupancy", to_pe_valid, eq.size() > 0);
`ifdef NOC_LOCAL_PORT_STATS_EN
            check("stat_in_cnt", stat_in_cnt, 32'(in_cnt));
            check("stat_out_cnt", stat_out_cnt, 32'(out_cnt));
`endif
            if (xbar_out_valid && xbar_out_ready) begin
                xbar_pops++;
                if (iq.size() == 0) begin
                    check("ingress_unexpected_flit", 1'b1, 1'b0);
                end else begin
                    logic [TW+4:0] e;
                    e = iq.pop_front();
                    check("xbar_out_data", xbar_out_data, e[TW-1:0]);
                    check("xbar_out_port", xbar_out_port, e[TW+4:TW]);
                end
            end
            if (to_pe_valid && to_pe_ready) begin
                pe_pops++;
                out_cnt++;
                if (eq.size() == 0) begin
                    check("egress_unexpected_flit", 1'b1, 1'b0);
                end else begin
                    check("to_pe_data", to_pe_data, eq.pop_front());
                end
            end
            if (pe_valid && pe_ready) begin
                iq.push_back({ref_route(pe_data), pe_data});
                in_cnt++;
            end
            if (xbar_in_valid && xbar_in_ready) begin
                eq.push_back(xbar_in_data);
            end
            prev_rst = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the flit until accepted; returns the cycles it took.
    task automatic push_in(input logic [TW-1:0] d, output int n);
        logic acc;
        n = 0;
        pe_data = d;
        pe_valid = 1'b1;
        do begin
            acc = pe_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("push_timeout", 1'b0, 1'b1);
        pe_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((iq.size() > 0 || eq.size() > 0) && n < 50) begin
            step();
            n++;
        end
        check(tag, 64'(iq.size() + eq.size()), 64'd0);
    endtask

    initial begin
        logic [TW-1:0] fa, fb, fc;
        logic [TW-1:0] ef [4];
        logic [4:0]    exp_ports [5];
        int            dsts [5][2];
        int            n, tot, base, k;
        logic          acc_in, acc_e;

        rst = 1'b1;
        pe_valid = 1'b1;
        pe_data = mk_flit(3, 1);
        xbar_out_ready = 1'b0;
        xbar_in_valid = 1'b0;
        xbar_in_data = '0;
        to_pe_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_xbar_out_valid", xbar_out_valid, 1'b0);
            check("rst_to_pe_valid", to_pe_valid, 1'b0);
            check("rst_port", xbar_out_port, 5'b0);
            check("rst_pe_ready", pe_ready, 1'b0);
            check("rst_xbar_in_ready", xbar_in_ready, 1'b0);
            check("rst_out_data", xbar_out_data, '0);
            check("rst_to_pe_data", to_pe_data, '0);
        end
        rst = 1'b0;
        pe_valid = 1'b0;
        step();
        check("post_rst_pe_ready", pe_ready, 1'b1);
        check("post_rst_xbar_in_ready", xbar_in_ready, 1'b1);
        check("post_rst_xbar_out_valid", xbar_out_valid, 1'b0);

        dsts = '{'{3, 1}, '{0, 1}, '{1, 3}, '{1, 0}, '{1, 1}};
        exp_ports = '{5'b01000, 5'b10000, 5'b00010, 5'b00100, 5'b00001};
        for (int i = 0; i < 5; i++) begin
            check("route_idle_valid", xbar_out_valid, 1'b0);
            push_in(mk_flit(dsts[i][0], dsts[i][1]), n);
            check("route_latency_valid", xbar_out_valid, 1'b1);
            check("route_port", xbar_out_port, exp_ports[i]);
            xbar_out_ready = 1'b1;
            step();
            xbar_out_ready = 1'b0;
        end

        fa = mk_flit(2, 0);
        fb = mk_flit(0, 3);
        fc = mk_flit(1, 2);
        push_in(fa, n);
        push_in(fb, n);
        check("bp_full_pe_ready", pe_ready, 1'b0);
        pe_data = fc;
        pe_valid = 1'b1;
        step();
        step();
        check("bp_hold_pe_ready", pe_ready, 1'b0);
        check("bp_head_is_a", xbar_out_data, fa);
        xbar_out_ready = 1'b1;
        push_in(fc, n);
        drain("bp_drain");

        base = xbar_pops;
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            push_in(mk_flit($urandom_range(0, 3), $urandom_range(0, 3)), n);
            tot += n;
        end
        check("stream_accept_cycles", 64'(tot), 64'd10);
        step();
        check("stream_output_cycles", 64'(xbar_pops - base), 64'd10);

        for (int i = 0; i < 4; i++) ef[i] = TW'($urandom);
        base = pe_pops;
        k = 0;
        for (int c = 0; c < 40 && (k < 4 || eq.size() > 0); c++) begin
            to_pe_ready = (c % 2 == 0);
            xbar_in_valid = (k < 4);
            xbar_in_data = ef[k < 4 ? k : 0];
            acc_e = xbar_in_valid && xbar_in_ready;
            step();
            if (acc_e) k++;
        end
        xbar_in_valid = 1'b0;
        to_pe_ready = 1'b1;
        check("egress_delivered", 64'(pe_pops - base), 64'd4);

        for (int c = 0; c < 300; c++) begin
            if (!pe_valid || acc_in) begin
                pe_valid = 1'($urandom_range(0, 1));
                pe_data = TW'($urandom);
            end
            if (!xbar_in_valid || acc_e) begin
                xbar_in_valid = 1'($urandom_range(0, 1));
                xbar_in_data = TW'($urandom);
            end
            xbar_out_ready = 1'($urandom_range(0, 1));
            to_pe_ready = 1'($urandom_range(0, 1));
            acc_in = pe_valid && pe_ready;
            acc_e = xbar_in_valid && xbar_in_ready;
            step();
        end
        pe_valid = 1'b0;
        xbar_in_valid = 1'b0;
        xbar_out_ready = 1'b1;
        to_pe_ready = 1'b1;
        drain("random_drain");

        xbar_out_ready = 1'b0;
        push_in(mk_flit(3, 3), n);
        push_in(mk_flit(0, 0), n);
        check("midrst_full", pe_ready, 1'b0);
        check("midrst_valid_before", xbar_out_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid_after", xbar_out_valid, 1'b0);
`ifdef NOC_LOCAL_PORT_STATS_EN
        check("midrst_stat_in", stat_in_cnt, 32'd0);
        check("midrst_stat_out", stat_out_cnt, 32'd0);
`endif
        xbar_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_stale", xbar_out_valid, 1'b0);
        end
        check("midrst_ready_back", pe_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
